// File: rtl/mpeg2_pkg.sv
// rtl/mpeg2_pkg.sv - shared frame geometry, address width and issue FSM states
package mpeg2_pkg;

    localparam int FRAME_W = 640;
    localparam int FRAME_H = 480;
    localparam int ADDR_W  = 19;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_READ = 1'b1
    } issue_state_t;

    // Saturate an 11-bit coordinate sum to the last valid pixel index.
    function automatic logic [10:0] clamp_coord(input logic [10:0] sum, input int limit);
        logic [10:0] max_c;
        max_c = 11'(limit - 1);
        return (sum > max_c) ? max_c : sum;
    endfunction

endpackage

// File: rtl/ref_pixel_server_if.sv
// rtl/ref_pixel_server_if.sv - requester and frame-memory signals of the reference pixel server
interface ref_pixel_server_if;

    logic [9:0]                   base_x;
    logic [9:0]                   base_y;
    logic                         base_ld;
    logic [3:0]                   mx;
    logic [3:0]                   my;
    logic                         mreq;
    logic                         m_wait;
    logic                         m_valid;
    logic [7:0]                   mq;
    logic [mpeg2_pkg::ADDR_W-1:0] mem_addr;
    logic                         mem_read;
    logic                         mem_waitrequest;
    logic [7:0]                   mem_readdata;
    logic                         mem_readdatavalid;

    modport slave (
        input  base_x, base_y, base_ld, mx, my, mreq,
        input  mem_waitrequest, mem_readdata, mem_readdatavalid,
        output m_wait, m_valid, mq, mem_addr, mem_read
    );

    modport master (
        output base_x, base_y, base_ld, mx, my, mreq,
        output mem_waitrequest, mem_readdata, mem_readdatavalid,
        input  m_wait, m_valid, mq, mem_addr, mem_read
    );

endinterface

// File: rtl/addr_fifo.sv
// rtl/addr_fifo.sv - request address queue exposing head, second entry and fill count
module addr_fifo
    import mpeg2_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [ADDR_W-1:0] push_data,
    input  logic              pop,
    output logic [ADDR_W-1:0] head,
    output logic [ADDR_W-1:0] second,
    output logic [CW-1:0]     count
);

    localparam int PW = $clog2(DEPTH);

    logic [ADDR_W-1:0] mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Second entry lets the issuer preload the next address on a pop.
    assign head   = mem[rd_ptr];
    assign second = mem[rd_ptr + PW'(1)];

endmodule

// File: rtl/ref_pixel_server.sv
// rtl/ref_pixel_server.sv - clamped reference pixel fetch with in-order returns and in-flight limit
module ref_pixel_server #(
    parameter int FRAME_W = mpeg2_pkg::FRAME_W,
    parameter int FRAME_H = mpeg2_pkg::FRAME_H,
    parameter int DEPTH   = 4
) (
    input  logic              clk,
    input  logic              reset,
    ref_pixel_server_if.slave bus
);

    localparam int AW = mpeg2_pkg::ADDR_W;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int IW = CW + 2;

    mpeg2_pkg::issue_state_t state;

    logic [9:0]    base_x_q;
    logic [9:0]    base_y_q;
    logic [CW-1:0] fifo_count;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] post_count;
    logic [IW-1:0] inflight;
    logic [AW-1:0] push_addr;
    logic [AW-1:0] head_addr;
    logic [AW-1:0] second_addr;
    logic [AW-1:0] next_head;
    logic [10:0]   sum_x;
    logic [10:0]   sum_y;
    logic [10:0]   clamp_x;
    logic [10:0]   clamp_y;
    logic          accept;
    logic          pop;
    logic          ret;

    // A pixel sitting in mq still counts against the limit until its m_valid cycle ends.
    assign inflight   = IW'(fifo_count) + IW'(outstanding) + IW'(bus.m_valid);
    assign bus.m_wait = (inflight >= IW'(DEPTH));

    assign accept = bus.mreq & ~bus.m_wait;
    assign pop    = (state == mpeg2_pkg::ST_READ) & ~bus.mem_waitrequest;
    assign ret    = bus.mem_readdatavalid & (outstanding != '0);

    assign sum_x     = {1'b0, base_x_q} + {7'd0, bus.mx};
    assign sum_y     = {1'b0, base_y_q} + {7'd0, bus.my};
    assign clamp_x   = mpeg2_pkg::clamp_coord(sum_x, FRAME_W);
    assign clamp_y   = mpeg2_pkg::clamp_coord(sum_y, FRAME_H);
    assign push_addr = AW'(clamp_y) * AW'(FRAME_W) + AW'(clamp_x);

    assign post_count = fifo_count + CW'(accept) - CW'(pop);

    // Address at the queue head after this edge, which may be the one being pushed now.
    always_comb begin
        next_head = head_addr;
        if (pop) begin
            next_head = (fifo_count > CW'(1)) ? second_addr : push_addr;
        end else if (fifo_count == '0) begin
            next_head = push_addr;
        end
    end

    addr_fifo #(
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_addr_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (accept),
        .push_data (push_addr),
        .pop       (pop),
        .head      (head_addr),
        .second    (second_addr),
        .count     (fifo_count)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= mpeg2_pkg::ST_IDLE;
            bus.mem_read <= 1'b0;
            bus.mem_addr <= '0;
            outstanding  <= '0;
        end else begin
            outstanding <= outstanding + CW'(pop) - CW'(ret);
            if (state == mpeg2_pkg::ST_IDLE) begin
                if (accept) begin
                    state        <= mpeg2_pkg::ST_READ;
                    bus.mem_read <= 1'b1;
                    bus.mem_addr <= next_head;
                end
            end else begin
                if (post_count == '0) begin
                    state        <= mpeg2_pkg::ST_IDLE;
                    bus.mem_read <= 1'b0;
                end else begin
                    bus.mem_addr <= next_head;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.m_valid <= 1'b0;
            bus.mq      <= '0;
            base_x_q    <= '0;
            base_y_q    <= '0;
        end else begin
            bus.m_valid <= ret;
            if (ret) begin
                bus.mq <= bus.mem_readdata;
            end
            if (bus.base_ld && (inflight == '0)) begin
                base_x_q <= bus.base_x;
                base_y_q <= bus.base_y;
            end
        end
    end

endmodule

// File: tb/tb_ref_pixel_server.sv
// tb/tb_ref_pixel_server.sv - directed self-checking bench for ref_pixel_server
module tb_ref_pixel_server;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ref_pixel_server_if bus();

    ref_pixel_server #(
        .FRAME_W (640),
        .FRAME_H (480),
        .DEPTH   (DEPTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    int         mem_lat   = 1;
    int         wait_mode = 0;
    logic [7:0] key       = 8'hC2;
    logic       pipe_v [8];
    logic [7:0] pipe_d [8];

    logic [7:0]  exp_q[$];
    logic [7:0]  got_q[$];
    logic [18:0] addr_q[$];
    logic [18:0] fired_q[$];
    int n_acc = 0, n_ret = 0, n_fire = 0, mem_valids = 0;
    int max_infl = 0, wait_bad = 0, addr_bad = 0;
    int mbx = 0, mby = 0;
    int mark;

    function automatic logic [18:0] model_addr(int bx, int by, int ox, int oy);
        int x, y;
        x = bx + ox;
        y = by + oy;
        if (x > 639) x = 639;
        if (y > 479) y = 479;
        return 19'(y * 640 + x);
    endfunction

    function automatic logic [7:0] pix(logic [18:0] a);
        return a[7:0] ^ key;
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // One clock: sample at negedge (scoreboard + model), then memory model acts 1 ns after posedge.
    task automatic cycle();
        int          infl;
        logic        fire;
        logic [18:0] faddr;
        logic [18:0] a;
        @(negedge clk);
        infl = n_acc - n_ret;
        if (infl > max_infl) max_infl = infl;
        if (bus.m_wait !== (infl >= DEPTH)) wait_bad++;
        if (bus.m_valid === 1'b1) got_q.push_back(bus.mq);
        if (bus.mreq && !bus.m_wait) begin
            a = model_addr(mbx, mby, int'(bus.mx), int'(bus.my));
            addr_q.push_back(a);
            exp_q.push_back(pix(a));
            n_acc++;
        end
        if (bus.base_ld && infl == 0) begin
            mbx = int'(bus.base_x);
            mby = int'(bus.base_y);
        end
        fire  = bus.mem_read && !bus.mem_waitrequest;
        faddr = bus.mem_addr;
        if (fire) begin
            fired_q.push_back(faddr);
            n_fire++;
            if (addr_q.size() == 0) addr_bad++;
            else if (addr_q.pop_front() !== faddr) addr_bad++;
        end
        if (bus.m_valid === 1'b1) n_ret++;
        @(posedge clk);
        #1;
        for (int i = 0; i < 7; i++) begin
            pipe_v[i] = pipe_v[i+1];
            pipe_d[i] = pipe_d[i+1];
        end
        pipe_v[7] = 1'b0;
        pipe_d[7] = 8'h00;
        pipe_v[mem_lat-1] = fire;
        pipe_d[mem_lat-1] = pix(faddr);
        bus.mem_readdatavalid = pipe_v[0];
        bus.mem_readdata      = pipe_v[0] ? pipe_d[0] : 8'h00;
        if (pipe_v[0]) mem_valids++;
        bus.mem_waitrequest = (wait_mode == 1) || (wait_mode == 2 && $urandom_range(0, 9) < 3);
    endtask

    task automatic drain(int n);
        repeat (n) cycle();
    endtask

    task automatic compare(string tag, int n);
        int bad;
        bad = 0;
        check({tag, "_count"}, got_q.size(), n);
        check({tag, "_exp_count"}, exp_q.size(), n);
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            if (got_q[i] !== exp_q[i]) bad++;
        end
        check({tag, "_order"}, bad, 0);
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic load_base(int bx, int by);
        bus.base_x  = 10'(bx);
        bus.base_y  = 10'(by);
        bus.base_ld = 1'b1;
        cycle();
        bus.base_ld = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        bus.base_x = '0; bus.base_y = '0; bus.base_ld = 1'b0;
        bus.mx = '0; bus.my = '0; bus.mreq = 1'b0;
        bus.mem_waitrequest = 1'b0; bus.mem_readdata = '0; bus.mem_readdatavalid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            pipe_v[i] = 1'b0;
            pipe_d[i] = 8'h00;
        end
        repeat (2) @(posedge clk);
        #1;
        check("rst_m_wait", bus.m_wait, 0);
        check("rst_m_valid", bus.m_valid, 0);
        check("rst_mq", bus.mq, 0);
        check("rst_mem_read", bus.mem_read, 0);
        check("rst_mem_addr", bus.mem_addr, 0);
        reset = 1'b0;
        cycle();

        // Basic fetch: (100,50)+(3,2) -> 52*640+103
        load_base(100, 50);
        bus.mx = 4'd3; bus.my = 4'd2; bus.mreq = 1'b1;
        cycle();
        bus.mreq = 1'b0;
        check("s1_mem_read", bus.mem_read, 1);
        check("s1_mem_addr", bus.mem_addr, 33383);
        cycle();
        check("s1_read_single", bus.mem_read, 0);
        check("s1_no_early_valid", bus.m_valid, 0);
        cycle();
        check("s1_m_valid", bus.m_valid, 1);
        check("s1_mq", bus.mq, 8'hA5);
        cycle();
        check("s1_valid_one_cycle", bus.m_valid, 0);

        // Clamping at the bottom-right corner
        load_base(635, 478);
        bus.mx = 4'd15; bus.my = 4'd15; bus.mreq = 1'b1;
        cycle();
        bus.mreq = 1'b0;
        check("s2_mem_read", bus.mem_read, 1);
        check("s2_mem_addr", bus.mem_addr, 307199);
        drain(6);
        check("s2_pixel", got_q.size() > 1 ? got_q[1] : 8'hxx, 8'h3D);
        compare("s12", 2);

        // Stalled memory: only DEPTH requests accepted
        load_base(7, 9);
        wait_mode = 1;
        bus.mem_waitrequest = 1'b1;
        mark = n_acc;
        for (int i = 0; i < 256; i++) begin
            bus.mreq = 1'b1;
            bus.mx = 4'(i % 16);
            bus.my = 4'((i / 16) % 16);
            cycle();
        end
        bus.mreq = 1'b0;
        check("s3_accepted", n_acc - mark, 4);
        check("s3_m_wait", bus.m_wait, 1);
        check("s3_addr_held", bus.mem_addr, 5767);
        check("s3_no_returns", got_q.size(), 0);
        wait_mode = 0;
        bus.mem_waitrequest = 1'b0;
        drain(20);
        compare("s3", 4);
        check("s3_m_wait_release", bus.m_wait, 0);

        // Latency 3 with random stalls against the reference model
        mem_lat = 3;
        wait_mode = 2;
        max_infl = 0;
        load_base(200, 100);
        mark = n_acc;
        for (int c = 0; c < 5000 && (n_acc - mark) < 256; c++) begin
            bus.mreq = ($urandom_range(0, 3) != 0);
            bus.mx = 4'($urandom_range(0, 15));
            bus.my = 4'($urandom_range(0, 15));
            cycle();
        end
        bus.mreq = 1'b0;
        check("s4_accepted", n_acc - mark, 256);
        drain(60);
        wait_mode = 0;
        bus.mem_waitrequest = 1'b0;
        drain(10);
        compare("s4", 256);
        check("s4_max_inflight_le_depth", max_infl <= DEPTH, 1);

        // Reset with 3 outstanding; late responses must be ignored
        mem_lat = 6;
        mark = n_fire;
        for (int i = 0; i < 3; i++) begin
            bus.mreq = 1'b1;
            bus.mx = 4'(i);
            bus.my = 4'd0;
            cycle();
        end
        bus.mreq = 1'b0;
        cycle();
        check("s5_issued", n_fire - mark, 3);
        reset = 1'b1;
        #1;
        check("s5_rst_m_valid", bus.m_valid, 0);
        check("s5_rst_mem_read", bus.mem_read, 0);
        check("s5_rst_m_wait", bus.m_wait, 0);
        n_acc = 0; n_ret = 0;
        got_q.delete(); exp_q.delete(); addr_q.delete();
        mbx = 0; mby = 0;
        cycle();
        reset = 1'b0;
        mark = mem_valids;
        drain(10);
        check("s5_late_responses_seen", mem_valids - mark, 3);
        check("s5_no_m_valid", got_q.size(), 0);
        check("s5_m_wait", bus.m_wait, 0);

        // base_ld with requests in flight is ignored
        fired_q.delete();
        load_base(10, 20);
        for (int i = 0; i < 2; i++) begin
            bus.mreq = 1'b1;
            bus.mx = 4'd0;
            bus.my = 4'd0;
            cycle();
        end
        bus.mreq = 1'b0;
        load_base(300, 300);
        bus.mx = 4'd1; bus.my = 4'd1; bus.mreq = 1'b1;
        cycle();
        bus.mreq = 1'b0;
        drain(15);
        check("s6_old_base_addr", fired_q.size() > 2 ? fired_q[2] : 19'h7FFFF, 13451);
        bus.mx = 4'd0; bus.my = 4'd0; bus.mreq = 1'b1;
        cycle();
        bus.mreq = 1'b0;
        drain(15);
        check("s6_base_kept", fired_q.size() > 3 ? fired_q[3] : 19'h7FFFF, 12810);
        compare("s6", 4);

        check("m_wait_model", wait_bad, 0);
        check("issue_order", addr_bad, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ref_pixel_server.md
REF_PIXEL_SERVER -- requirements
Module: ref_pixel_server

Interface
REQ-001 SHALL have parameters (name, default, meaning):
 - FRAME_W, 640, frame width in pixels
 - FRAME_H, 480, frame height in pixels
 - DEPTH, 4, maximum requests in flight, power of two, 2..16
REQ-002 SHALL have ports (name, direction, width, meaning):
 - clk, in, 1, single clock, rising edge
 - reset, in, 1, asynchronous active-high reset
 - base_x, in, 10, candidate block origin x
 - base_y, in, 10, candidate block origin y
 - base_ld, in, 1, latch base_x/base_y
 - mx, in, 4, x offset of request
 - my, in, 4, y offset of request
 - mreq, in, 1, request strobe
 - m_wait, out, 1, no request accepted this cycle
 - m_valid, out, 1, mq carries a returned pixel
 - mq, out, 8, pixel value
 - mem_addr, out, 19, frame memory byte address
 - mem_read, out, 1, memory read strobe
 - mem_waitrequest, in, 1, memory stall
 - mem_readdata, in, 8, memory read data
 - mem_readdatavalid, in, 1, memory read data valid

Function
REQ-003 SHALL latch base_x/base_y on base_ld only when in-flight count is 0; base_ld at any other time SHALL be ignored.
REQ-004 In-flight count SHALL equal queued requests plus issued-unreturned reads plus a pending mq register (0 or 1).
REQ-005 m_wait SHALL be combinational from registered state only, high iff in-flight count >= DEPTH.
REQ-006 mreq with m_wait low SHALL be accepted: address (clamp_y)*FRAME_W + clamp_x pushed into the address queue in the same edge.
REQ-007 clamp_x = min(base_x+mx, FRAME_W-1); clamp_y = min(base_y+my, FRAME_H-1); sums computed at 11 bits, no wrap.
REQ-008 mreq with m_wait high SHALL be dropped with no state change.
REQ-009 Issue FSM SHALL have two states:
 - IDLE: mem_read=0; goes to READ when the queue is non-empty.
 - READ: mem_read=1, mem_addr=queue head, held stable while mem_waitrequest=1.
 - READ, mem_waitrequest=0: pop queue, increment outstanding; stay in READ if the queue still holds an entry after the pop, else IDLE.
REQ-010 Earliest mem_read SHALL be the cycle after mreq acceptance; back-to-back reads at one per cycle SHALL be sustained when mem_waitrequest=0.
REQ-011 mem_readdatavalid with outstanding>0 SHALL register mem_readdata into mq and assert m_valid for exactly the next cycle, decrementing outstanding.
REQ-012 mem_readdatavalid with outstanding=0 SHALL be ignored (stale response after reset).
REQ-013 Pixels SHALL return in request order; the memory is in-order.
REQ-014 Simultaneous push, issue pop, and return in one cycle SHALL update all counts correctly with net change computed, no lost or duplicated request.
REQ-015 No consumer backpressure: the consumer SHALL accept every m_valid pulse.

Reset
REQ-016 reset SHALL asynchronously clear:
 - FSM to IDLE
 - queue pointers and all counts to 0
 - base registers to 0
 - m_valid=0, mq=0, mem_read=0, mem_addr=0
 - m_wait consequently low
REQ-017 Reset mid-operation SHALL discard all queued and outstanding requests; late memory responses SHALL fall under REQ-012.

Structure
REQ-018 FRAME_W, FRAME_H, address width 19, and the FSM state enum SHALL live in shared package mpeg2_pkg.
REQ-019 The address queue SHALL be a sub-module addr_fifo (synchronous, DEPTH entries, 19-bit, count output).

Verification
REQ-020 Bench SHALL cover these directed scenarios:
 - base (100,50), mx=3,my=2, zero-wait memory, 1-cycle latency -> mem_addr=52*640+103=33383 one cycle after mreq; m_valid with returned byte 0xA5 two cycles after mem_read.
 - base (635,478), mx=15,my=15 -> clamped to (639,479), mem_addr=307199.
 - 256 back-to-back requests, mem_waitrequest=1 continuously -> m_wait high after 4 accepted; further mreq dropped; release -> exactly 4 m_valid in order.
 - Memory latency 3, random mem_waitrequest 30% -> 256 returns matching a reference model in order; in-flight count never exceeds 4.
 - reset with 3 outstanding, then 3 late mem_readdatavalid -> m_valid stays 0, m_wait 0.
 - base_ld while in-flight=2 -> base unchanged; next request uses the old base.
